// File: rtl/tensor_cpu_pkg.sv
// tensor_cpu_pkg: shared types and constants for the tensor_cpu slice.
//   - default datapath/register/matrix-size constants
//   - 8-bit opcode enum and multiply-sequencer state enum
//   - sat_add(): unsigned add clamped to 2^w-1 (w <= 31), used when the
//     TENSOR_CPU_SATURATE_EN build option is defined
package tensor_cpu_pkg;

    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_NUM_REGS = 16;
    localparam int unsigned DEF_DIM      = 4;

    typedef enum logic [7:0] {
        OP_NOP  = 8'h00,
        OP_ADD  = 8'h01,
        OP_SUB  = 8'h02,
        OP_AND  = 8'h03,
        OP_OR   = 8'h04,
        OP_ADDI = 8'h05,
        OP_TLI  = 8'h06,
        OP_TMV  = 8'h07,
        OP_TMMA = 8'h08,
        OP_TRD  = 8'h09
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } mma_state_e;

    // Either operand may already exceed 2^w-1 (the raw product); the 33-bit
    // sum cannot overflow, so one compare clamps both operand and result.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = (33'd1 << w) - 33'd1;
        return (sum > max) ? max[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/tensor_mac_sequencer.sv
// tensor_mac_sequencer: sequences C = A x B one multiply-accumulate per cycle.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   start_i        accepted TMMA (only honoured in IDLE)
//   a_i, b_i       banks A/B, row-major, read combinationally
//   busy_o         state != IDLE
//   done_o         one-cycle pulse in DONE
//   c_o            result bank C, row-major
// Build option TENSOR_CPU_SATURATE_EN: accumulate with unsigned saturation
// instead of wrapping modulo 2^DATA_W. Supports DATA_W <= 16.
module tensor_mac_sequencer
    import tensor_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DIM    = DEF_DIM
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 start_i,
    input  logic [DIM-1:0][DIM-1:0][DATA_W-1:0]  a_i,
    input  logic [DIM-1:0][DIM-1:0][DATA_W-1:0]  b_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [DIM-1:0][DIM-1:0][DATA_W-1:0]  c_o
);

    localparam int unsigned   CW   = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIM - 1);

    mma_state_e                          state_q, state_d;
    logic [CW-1:0]                       i_q, i_d, j_q, j_d, k_q, k_d;
    logic [DATA_W-1:0]                   acc_q, acc_d, sum;
    logic [2*DATA_W-1:0]                 prod;
    logic [DIM-1:0][DIM-1:0][DATA_W-1:0] c_q, c_d;

    assign prod = (2*DATA_W)'(a_i[i_q][k_q]) * (2*DATA_W)'(b_i[k_q][j_q]);

`ifdef TENSOR_CPU_SATURATE_EN
    assign sum = DATA_W'(sat_add(32'(acc_q), 32'(prod), DATA_W));
`else
    logic unused_prod_hi;
    assign unused_prod_hi = ^prod[2*DATA_W-1:DATA_W];
    assign sum = acc_q + prod[DATA_W-1:0];
`endif

    assign c_o = c_q;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        c_d     = c_q;
        busy_o  = (state_q != ST_IDLE);
        done_o  = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_MAC;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            ST_MAC: begin
                if (k_q == LAST) begin
                    // Last term of the dot product goes straight to C.
                    c_d[i_q][j_q] = sum;
                    acc_d         = '0;
                    k_d           = '0;
                    if (j_q == LAST) begin
                        j_d = '0;
                        if (i_q == LAST) begin
                            i_d     = '0;
                            state_d = ST_DONE;
                        end else begin
                            i_d = i_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    acc_d = sum;
                    k_d   = k_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
        end
    end

endmodule

// File: rtl/tensor_cpu.sv
// tensor_cpu: accumulator CPU with immediate ops, gated register writes and a
// DIM x DIM matrix-multiply engine behind a valid/ready instruction handshake.
// Ports:
//   clock_in, reset_in        clock, asynchronous active-high reset
//   instr_valid_in            current_instruction_in is valid
//   current_instruction_in    [31:24] rd, [23:16] rs1/imm, [15:8] rs2, [7:0] op
//   instr_ready_out           high while no multiply is in flight
//   cpu_output                last register-writing result (registered)
//   mma_busy_out              multiply in progress
//   mma_done_out              one-cycle pulse when bank C is complete
//   tensor_result_out         bank C, row-major
// Build option TENSOR_CPU_SATURATE_EN selects saturating multiply-accumulate.
// Requires DIM >= 2, NUM_REGS >= 2, DATA_W <= 16.
module tensor_cpu
    import tensor_cpu_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned DIM      = DEF_DIM
) (
    input  logic                                 clock_in,
    input  logic                                 reset_in,
    input  logic                                 instr_valid_in,
    input  logic [31:0]                          current_instruction_in,
    output logic                                 instr_ready_out,
    output logic [DATA_W-1:0]                    cpu_output,
    output logic                                 mma_busy_out,
    output logic                                 mma_done_out,
    output logic [DIM-1:0][DIM-1:0][DATA_W-1:0]  tensor_result_out
);

    localparam int unsigned NE = DIM * DIM;
    localparam int unsigned RW = $clog2(NUM_REGS);
    localparam int unsigned IW = $clog2(NE);

    logic [7:0]                        rd_f, rs1_f, rs2_f, op_f;
    logic [RW-1:0]                     rd, rs1, rs2;
    logic [IW-1:0]                     dst_idx, src_idx;
    logic                              dst_bank, accept, mma_start;
    logic [DATA_W-1:0]                 imm, wr_val, tensor_val;
    logic                              wr_en, tensor_wr;
    logic [NUM_REGS-1:0][DATA_W-1:0]   regs_q, regs_d;
    logic [NE-1:0][DATA_W-1:0]         a_q, a_d, b_q, b_d, c_flat;
    logic [DATA_W-1:0]                 cpu_q, cpu_d;
    logic                              unused_fields;

    assign {rd_f, rs1_f, rs2_f, op_f} = current_instruction_in;
    assign unused_fields = ^{rd_f, rs1_f, rs2_f};

    assign rd       = rd_f[RW-1:0];
    assign rs1      = rs1_f[RW-1:0];
    assign rs2      = rs2_f[RW-1:0];
    assign dst_idx  = rd_f[IW-1:0];
    assign dst_bank = rd_f[IW];
    assign src_idx  = rs1_f[IW-1:0];
    assign imm      = DATA_W'(rs1_f);

    assign instr_ready_out = !mma_busy_out;
    assign accept          = instr_valid_in && instr_ready_out;
    assign mma_start       = accept && (op_f == OP_TMMA);
    assign cpu_output      = cpu_q;
    assign c_flat          = tensor_result_out;

    always_comb begin
        regs_d     = regs_q;
        cpu_d      = cpu_q;
        a_d        = a_q;
        b_d        = b_q;
        wr_en      = 1'b0;
        wr_val     = '0;
        tensor_wr  = 1'b0;
        tensor_val = '0;
        if (accept) begin
            case (op_f)
                OP_ADD:  begin wr_en = 1'b1; wr_val = regs_q[rs1] + regs_q[rs2]; end
                OP_SUB:  begin wr_en = 1'b1; wr_val = regs_q[rs1] - regs_q[rs2]; end
                OP_AND:  begin wr_en = 1'b1; wr_val = regs_q[rs1] & regs_q[rs2]; end
                OP_OR:   begin wr_en = 1'b1; wr_val = regs_q[rs1] | regs_q[rs2]; end
                OP_ADDI: begin wr_en = 1'b1; wr_val = imm + regs_q[rs2]; end
                OP_TRD:  begin wr_en = 1'b1; wr_val = c_flat[src_idx]; end
                OP_TLI:  begin tensor_wr = 1'b1; tensor_val = imm; end
                OP_TMV:  begin tensor_wr = 1'b1; tensor_val = regs_q[rs1]; end
                default: ;
            endcase
        end
        if (wr_en) begin
            regs_d[rd] = wr_val;
            cpu_d      = wr_val;
        end
        if (tensor_wr) begin
            if (dst_bank) b_d[dst_idx] = tensor_val;
            else          a_d[dst_idx] = tensor_val;
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            regs_q <= '0;
            cpu_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            regs_q <= regs_d;
            cpu_q  <= cpu_d;
            a_q    <= a_d;
            b_q    <= b_d;
        end
    end

    tensor_mac_sequencer #(
        .DATA_W (DATA_W),
        .DIM    (DIM)
    ) u_seq (
        .clk_i   (clock_in),
        .rst_i   (reset_in),
        .start_i (mma_start),
        .a_i     (a_q),
        .b_i     (b_q),
        .busy_o  (mma_busy_out),
        .done_o  (mma_done_out),
        .c_o     (tensor_result_out)
    );

endmodule

// File: tb/tb_tensor_cpu.sv
module tb_tensor_cpu;

    localparam int unsigned W  = 8;
    localparam int unsigned NR = 16;
    localparam int unsigned D  = 4;
    localparam int unsigned NE = D * D;
    localparam int unsigned BOUND = 300;

    logic                        clk   = 1'b0;
    logic                        rst   = 1'b1;
    logic                        valid = 1'b0;
    logic [31:0]                 instr = '0;
    logic                        ready, busy, done;
    logic [W-1:0]                cpu;
    logic [D-1:0][D-1:0][W-1:0]  c_out;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Architectural reference state
    int unsigned m_reg[NR];
    int unsigned m_a[NE];
    int unsigned m_b[NE];
    int unsigned m_c[NE];
    int unsigned m_cpu;

    tensor_cpu #(
        .DATA_W   (W),
        .NUM_REGS (NR),
        .DIM      (D)
    ) dut (
        .clock_in               (clk),
        .reset_in               (rst),
        .instr_valid_in         (valid),
        .current_instruction_in (instr),
        .instr_ready_out        (ready),
        .cpu_output             (cpu),
        .mma_busy_out           (busy),
        .mma_done_out           (done),
        .tensor_result_out      (c_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input int unsigned op, input int unsigned rd,
                                       input int unsigned rs1, input int unsigned rs2);
        return {rd[7:0], rs1[7:0], rs2[7:0], op[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_c(input string tag);
        for (int i = 0; i < NE; i++)
            chk($sformatf("%s C[%0d]", tag, i), 32'(c_out[i / D][i % D]), m_c[i]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_reg[i] = 0;
        for (int i = 0; i < NE; i++) begin m_a[i] = 0; m_b[i] = 0; m_c[i] = 0; end
        m_cpu = 0;
    endtask

    // Matrix product from the definition: full dot product, then reduce.
    // Saturating per-step adds of non-negative terms equal min(total, max).
    task automatic model_mma();
        int unsigned s;
        for (int i = 0; i < D; i++)
            for (int j = 0; j < D; j++) begin
                s = 0;
                for (int k = 0; k < D; k++) s += m_a[i*D + k] * m_b[k*D + j];
`ifdef TENSOR_CPU_SATURATE_EN
                m_c[i*D + j] = (s > 255) ? 255 : s;
`else
                m_c[i*D + j] = s % 256;
`endif
            end
    endtask

    task automatic model_exec(input logic [31:0] ins);
        int unsigned op  = ins[7:0];
        int unsigned rd  = ins[31:24];
        int unsigned rs1 = ins[23:16];
        int unsigned rs2 = ins[15:8];
        int unsigned a   = m_reg[rs1 % NR];
        int unsigned b   = m_reg[rs2 % NR];
        int unsigned v   = 0;
        bit          wr  = 1'b1;
        case (op)
            1: v = (a + b) % 256;
            2: v = (a + 256 - b) % 256;
            3: v = a & b;
            4: v = a | b;
            5: v = (rs1 + b) % 256;
            9: v = m_c[rs1 % NE];
            6, 7: begin
                wr = 1'b0;
                v  = (op == 6) ? rs1 : a;
                if (((rd / NE) % 2) == 1) m_b[rd % NE] = v;
                else                      m_a[rd % NE] = v;
            end
            8: begin wr = 1'b0; model_mma(); end
            default: wr = 1'b0;
        endcase
        if (wr) begin
            m_reg[rd % NR] = v;
            m_cpu = v;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [31:0] ins, output int unsigned waited);
        valid  = 1'b1;
        instr  = ins;
        waited = 0;
        while (ready !== 1'b1 && waited < BOUND) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= BOUND) chk("accept_timeout", 32'(ready), 1);
        @(negedge clk);
        valid = 1'b0;
        instr = '0;
    endtask

    task automatic exec(input logic [31:0] ins);
        int unsigned w;
        issue(ins, w);
        model_exec(ins);
    endtask

    task automatic run_mma(input string tag);
        int unsigned s, busy_n, done_n, done_at, ready_at;
        exec(mk(8, 0, 0, 0));
        s = 1; busy_n = 0; done_n = 0; done_at = 0; ready_at = 0;
        while (ready_at == 0 && s <= BOUND) begin
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) begin done_n++; done_at = s; end
            if (ready === 1'b1) ready_at = s;
            else begin @(negedge clk); s++; end
        end
        chk({tag, " busy_cycles"}, busy_n, 65);
        chk({tag, " done_count"}, done_n, 1);
        chk({tag, " done_at"}, done_at, 65);
        chk({tag, " ready_at"}, ready_at, 66);
        check_c(tag);
    endtask

    task automatic load_banks(input int mode);
        int unsigned v, r;
        for (int i = 0; i < NE; i++) begin
            for (int bank = 0; bank < 2; bank++) begin
                case (mode)
                    0: v = (bank == 0) ? ((i / D == i % D) ? 1 : 0) : i;
                    1: v = 16;
                    default: v = $urandom_range(0, 255);
                endcase
                if (mode >= 2 && $urandom_range(0, 1) == 1) begin
                    r = $urandom_range(0, NR - 1);
                    exec(mk(7, bank * NE + i, r, 0));
                end else begin
                    exec(mk(6, bank * NE + i, v, 0));
                end
            end
        end
    endtask

    initial begin
        int unsigned w, op;
        logic [31:0] ins;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("reset ready", 32'(ready), 1);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset cpu", 32'(cpu), 0);
        check_c("reset");

        // Dependent back-to-back arithmetic
        exec(mk(5, 1, 5, 0));
        chk("addi r1 cpu", 32'(cpu), 5);
        exec(mk(1, 2, 1, 1));
        chk("add r2 cpu", 32'(cpu), 10);
        exec(mk(1, 5, 2, 0));
        chk("r2 readback", 32'(cpu), 10);

        // Unknown opcode behaves as NOP but is accepted
        exec(mk(5, 3, 77, 0));
        chk("addi r3 cpu", 32'(cpu), m_cpu);
        issue(mk(8'hFF, 3, 9, 1), w);
        model_exec(mk(8'hFF, 3, 9, 1));
        chk("unk accepted", w, 0);
        chk("unk cpu", 32'(cpu), m_cpu);
        chk("unk ready", 32'(ready), 1);
        exec(mk(4, 7, 3, 0));
        chk("unk r3 kept", 32'(cpu), m_cpu);

        // Randomised ALU traffic
        for (int n = 0; n < 24; n++) begin
            op  = $urandom_range(1, 5);
            ins = mk(op, $urandom_range(0, NR - 1), (op == 5) ? $urandom_range(0, 255)
                     : $urandom_range(0, NR - 1), $urandom_range(0, NR - 1));
            exec(ins);
            chk($sformatf("alu%0d op%0d", n, op), 32'(cpu), m_cpu);
        end

        // Identity x index matrix
        load_banks(0);
        run_mma("ident");
        exec(mk(9, 4, 5, 0));
        chk("trd c5", 32'(cpu), m_cpu);
        chk("trd c5 abs", 32'(cpu), 5);

        // Hold a bank write while the multiply runs
        exec(mk(8, 0, 0, 0));
        issue(mk(6, 0, 3, 0), w);
        chk("held wait", w, 65);
        check_c("held old A");
        model_exec(mk(6, 0, 3, 0));
        run_mma("held new A");

        // Overflow of accumulation
        load_banks(1);
        run_mma("all16");

        // Random matrices, mixed TLI/TMV loads
        for (int n = 0; n < 2; n++) begin
            load_banks(2);
            run_mma($sformatf("rand%0d", n));
        end

        // Asynchronous reset part-way through a multiply
        exec(mk(8, 0, 0, 0));
        repeat (19) @(negedge clk);
        chk("pre-rst busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst ready", 32'(ready), 1);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst cpu", 32'(cpu), 0);
        check_c("rst");
        @(negedge clk);
        rst = 1'b0;
        load_banks(2);
        run_mma("post-rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
